// File: rtl/score_counter.sv
// Bounded up/down score counter with saturate-or-wrap arithmetic, synchronous
// clear/load and press-and-hold auto-repeat driven by debounced button levels.
module score_counter #(
   parameter int BW      = 7,
   parameter int MAX_VAL = 99,
   parameter int WRAP    = 0,
   parameter int STEP    = 1,
   parameter int RPT_DLY = 8,
   parameter int RPT_PER = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          up_i,
   input  logic          dn_i,
   input  logic          load_i,
   input  logic [BW-1:0] load_val_i,
   output logic [BW-1:0] cnt_o,
   output logic          at_max_o,
   output logic          at_min_o,
   output logic          step_o
);

   localparam int TMR_TOP = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
   localparam int TW      = $clog2(TMR_TOP);

   localparam logic [TW-1:0] DLY_END = TW'(RPT_DLY - 1);
   localparam logic [TW-1:0] PER_END = TW'(RPT_PER - 1);

   localparam logic [BW:0]   MAX_X  = (BW+1)'(MAX_VAL);
   localparam logic [BW:0]   MOD_X  = (BW+1)'(MAX_VAL + 1);
   localparam logic [BW:0]   STEP_X = (BW+1)'(STEP);
   localparam logic [BW-1:0] MAX_N  = BW'(MAX_VAL);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_e;

   // Bit 1 = up, bit 0 = down; both-pressed collapses to DIR_NONE.
   typedef enum logic [1:0] {
      DIR_NONE = 2'b00,
      DIR_DN   = 2'b01,
      DIR_UP   = 2'b10
   } dir_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tmr_q,   tmr_d;
   dir_e            p_q,     p_d;
   logic [BW-1:0]   cnt_q,   cnt_d;
   logic            step_q,  step_d;

   dir_e            p;
   logic            ev;
   logic [BW:0]     cnt_x;
   logic [BW:0]     sum;
   logic [BW:0]     up_val;
   logic [BW:0]     dn_val;
   logic [BW:0]     ev_val;

   // Repeat FSM: decides when an up/down event fires.
   // NOTE: every variable written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      p       = dir_e'({up_i & ~dn_i, dn_i & ~up_i});
      p_d     = p;
      state_d = state_q;
      tmr_d   = tmr_q;
      ev      = 1'b0;

      if (p == DIR_NONE) begin
         state_d = IDLE;
         tmr_d   = '0;
      end else if (p != p_q) begin
         ev      = 1'b1;
         state_d = DELAY;
         tmr_d   = '0;
      end else begin
         unique case (state_q)
            DELAY: begin
               if (tmr_q == DLY_END) begin
                  ev      = 1'b1;
                  state_d = REPEAT;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            REPEAT: begin
               if (tmr_q == PER_END) begin
                  ev    = 1'b1;
                  tmr_d = '0;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               tmr_d   = '0;
            end
         endcase
      end
   end

   // Bounded arithmetic in BW+1 bits so the carry out of cnt+STEP is visible.
   always_comb begin
      cnt_x = {1'b0, cnt_q};
      sum   = cnt_x + STEP_X;

      if (sum > MAX_X) begin
         up_val = (WRAP != 0) ? (sum - MOD_X) : MAX_X;
      end else begin
         up_val = sum;
      end

      if (cnt_x < STEP_X) begin
         dn_val = (WRAP != 0) ? (cnt_x + MOD_X - STEP_X) : '0;
      end else begin
         dn_val = cnt_x - STEP_X;
      end

      ev_val = (p == DIR_UP) ? up_val : dn_val;
   end

   // Clear beats load beats event; only a real count change pulses step.
   always_comb begin
      cnt_d  = cnt_q;
      step_d = 1'b0;

      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = ({1'b0, load_val_i} > MAX_X) ? MAX_N : load_val_i;
      end else if (ev) begin
         cnt_d  = ev_val[BW-1:0];
         step_d = (ev_val != cnt_x);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         p_q     <= DIR_NONE;
         cnt_q   <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign at_max_o = (cnt_q == MAX_N);
   assign at_min_o = (cnt_q == '0);
   assign step_o   = step_q;

endmodule

// File: tb/tb_score_counter.sv
// Scoreboard bench for score_counter: a saturating (defaults) and a wrapping
// (WRAP=1, STEP=3) instance share stimulus and are checked against a schedule model.
module tb_score_counter;

   localparam int BW     = 7;
   localparam int MAXV   = 99;
   localparam int DLY    = 8;
   localparam int PER    = 4;
   localparam int STEP_W = 3;

   logic          clk_i      = 1'b0;
   logic          rst_ni     = 1'b0;
   logic          clr_i      = 1'b0;
   logic          up_i       = 1'b0;
   logic          dn_i       = 1'b0;
   logic          load_i     = 1'b0;
   logic [BW-1:0] load_val_i = '0;

   logic [BW-1:0] cnt_s, cnt_w;
   logic          mx_s, mn_s, st_s;
   logic          mx_w, mn_w, st_w;

   score_counter u_sat (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (clr_i),
      .up_i       (up_i),
      .dn_i       (dn_i),
      .load_i     (load_i),
      .load_val_i (load_val_i),
      .cnt_o      (cnt_s),
      .at_max_o   (mx_s),
      .at_min_o   (mn_s),
      .step_o     (st_s)
   );

   score_counter #(.WRAP(1), .STEP(STEP_W)) u_wrap (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (clr_i),
      .up_i       (up_i),
      .dn_i       (dn_i),
      .load_i     (load_i),
      .load_val_i (load_val_i),
      .cnt_o      (cnt_w),
      .at_max_o   (mx_w),
      .at_min_o   (mn_w),
      .step_o     (st_w)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int cnt;
      bit mx;
      bit mn;
      bit st;
   } exp_t;

   exp_t q_s[$];
   exp_t q_w[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state: count per instance plus how long the current press lasted.
   int   m_cnt_s = 0;
   int   m_cnt_w = 0;
   int   prev_p  = 0;
   int   hold    = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int arith(input int c, input int dir, input int stp, input bit wrap);
      int r;
      if (dir == 1) begin
         if (c + stp > MAXV) r = wrap ? (c + stp) % (MAXV + 1) : MAXV;
         else                r = c + stp;
      end else begin
         if (c < stp) r = wrap ? (c - stp + MAXV + 1) % (MAXV + 1) : 0;
         else         r = c - stp;
      end
      return r;
   endfunction

   function automatic exp_t next_exp(input int c, input int dir, input bit ev, input bit clr,
                                     input bit ld, input int lval, input int stp, input bit wrap);
      exp_t e;
      int   a;
      e.st = 1'b0;
      if (clr) begin
         e.cnt = 0;
      end else if (ld) begin
         e.cnt = (lval > MAXV) ? MAXV : lval;
      end else if (ev) begin
         a     = arith(c, dir, stp, wrap);
         e.st  = (a != c);
         e.cnt = a;
      end else begin
         e.cnt = c;
      end
      e.mx = (e.cnt == MAXV);
      e.mn = (e.cnt == 0);
      return e;
   endfunction

   task automatic reset_model();
      m_cnt_s = 0;
      m_cnt_w = 0;
      prev_p  = 0;
      hold    = 0;
   endtask

   // Drive one cycle's inputs and push what both DUTs must show after the next edge.
   task automatic apply(input bit up, input bit dn, input bit clr, input bit ld, input int lval);
      int   p;
      bit   ev;
      exp_t es, ew;
      up_i       = up;
      dn_i       = dn;
      clr_i      = clr;
      load_i     = ld;
      load_val_i = BW'(lval);

      p  = (up && !dn) ? 1 : ((dn && !up) ? 2 : 0);
      ev = 1'b0;
      if (p == 0) begin
         hold = 0;
      end else if (p != prev_p) begin
         hold = 0;
         ev   = 1'b1;
      end else begin
         hold++;
         ev = (hold == DLY) || (hold > DLY && ((hold - DLY) % PER) == 0);
      end
      prev_p = p;

      es = next_exp(m_cnt_s, p, ev, clr, ld, lval, 1, 1'b0);
      ew = next_exp(m_cnt_w, p, ev, clr, ld, lval, STEP_W, 1'b1);
      m_cnt_s = es.cnt;
      m_cnt_w = ew.cnt;
      q_s.push_back(es);
      q_w.push_back(ew);
   endtask

   task automatic cycle(input bit up, input bit dn, input bit clr, input bit ld, input int lval);
      @(negedge clk_i);
      apply(up, dn, clr, ld, lval);
   endtask

   task automatic settle();
      @(posedge clk_i);
      #2;
   endtask

   // Monitor: every edge with a pending expectation is compared against both DUTs.
   always @(posedge clk_i) begin : monitor
      exp_t es, ew;
      #1;
      if (q_s.size() != 0 && q_w.size() != 0) begin
         es = q_s.pop_front();
         ew = q_w.pop_front();
         check("sat cnt",    int'(cnt_s), es.cnt);
         check("sat at_max", int'(mx_s),  int'(es.mx));
         check("sat at_min", int'(mn_s),  int'(es.mn));
         check("sat step",   int'(st_s),  int'(es.st));
         check("wrap cnt",   int'(cnt_w), ew.cnt);
         check("wrap at_max", int'(mx_w), int'(ew.mx));
         check("wrap at_min", int'(mn_w), int'(ew.mn));
         check("wrap step",  int'(st_w),  int'(ew.st));
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int dir;

      // Reset state
      repeat (2) @(negedge clk_i);
      check("reset cnt",    int'(cnt_s), 0);
      check("reset at_min", int'(mn_s),  1);
      check("reset at_max", int'(mx_s),  0);
      check("reset step",   int'(st_s),  0);
      check("reset wcnt",   int'(cnt_w), 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      reset_model();
      apply(0, 0, 0, 0, 0);

      // Asynchronous reset mid-cycle, then a held button fires on the first edge
      cycle(0, 0, 0, 1, 42);
      cycle(0, 0, 0, 0, 0);
      settle();
      check("load 42", int'(cnt_s), 42);
      @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check("async rst cnt",    int'(cnt_s), 0);
      check("async rst at_min", int'(mn_s),  1);
      repeat (2) @(negedge clk_i);
      reset_model();
      rst_ni = 1'b1;
      apply(1, 0, 0, 0, 0);
      settle();
      check("first edge after rst", int'(cnt_s), 1);
      cycle(0, 0, 0, 0, 0);

      // Single presses
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0);
      repeat (3) begin
         cycle(1, 0, 0, 0, 0);
         cycle(0, 0, 0, 0, 0);
      end
      settle();
      check("three up pulses", int'(cnt_s), 3);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      settle();
      check("one dn pulse", int'(cnt_s), 2);

      // Auto-repeat: 20-cycle hold gives events at offsets 0, 8, 12, 16
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0);
      repeat (20) cycle(1, 0, 0, 0, 0);
      settle();
      check("hold 20", int'(cnt_s), 4);
      repeat (6) cycle(0, 0, 0, 0, 0);
      settle();
      check("after release", int'(cnt_s), 4);

      // Saturation at both bounds
      cycle(0, 0, 0, 1, 98);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      settle();
      check("sat top cnt",    int'(cnt_s), 99);
      check("sat top at_max", int'(mx_s),  1);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 1, 0, 0, 0);
      settle();
      check("sat bottom cnt",  int'(cnt_s), 0);
      check("sat bottom step", int'(st_s),  0);
      cycle(0, 0, 0, 0, 0);

      // Wrap instance: 98 + 3 -> 1, 1 - 3 -> 98
      cycle(0, 0, 0, 1, 98);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      settle();
      check("wrap up cnt",  int'(cnt_w), 1);
      check("wrap up step", int'(st_w),  1);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      settle();
      check("wrap dn cnt",  int'(cnt_w), 98);
      check("wrap dn step", int'(st_w),  1);
      cycle(0, 0, 0, 0, 0);

      // Priority and simultaneous requests
      cycle(0, 0, 0, 1, 50);
      cycle(0, 0, 0, 0, 0);
      repeat (10) cycle(1, 1, 0, 0, 0);
      settle();
      check("both pressed", int'(cnt_s), 50);
      cycle(1, 0, 1, 0, 0);
      settle();
      check("clr over up cnt",  int'(cnt_s), 0);
      check("clr over up step", int'(st_s),  0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 120);
      settle();
      check("load clamp", int'(cnt_s), 99);
      check("load clamp w", int'(cnt_w), 99);

      // Randomized holds, switches, clears and loads
      dir = 0;
      for (int i = 0; i < 600; i++) begin
         bit up, dn, clr, ld;
         if ($urandom_range(0, 9) == 0) dir = int'($urandom_range(0, 3));
         up  = (dir == 1) || (dir == 3);
         dn  = (dir == 2) || (dir == 3);
         clr = ($urandom_range(0, 39) == 0);
         ld  = ($urandom_range(0, 29) == 0);
         cycle(up, dn, clr, ld, int'($urandom_range(0, 127)));
      end
      cycle(0, 0, 0, 0, 0);
      settle();
      check("scoreboard drained", q_s.size() + q_w.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
